// File: rtl/vedic_mul_pipe.sv
// Three-stage pipelined signed/unsigned multiplier built from Urdhva-Tiryagbhyam partial products.
// One beat per cycle with a single global stall when the output register is full and not taken.
module vedic_mul_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  if (WIDTH != 4 && WIDTH != 8 && WIDTH != 16 && WIDTH != 32) begin : gen_width_check
    $error("vedic_mul_pipe: WIDTH must be 4, 8, 16 or 32");
  end

  localparam int W  = int'(WIDTH);
  localparam int H  = W / 2;        // half-operand width
  localparam int HP = 2 * H;        // half-width product width
  localparam int PW = 2 * W;        // full product width
  localparam int ND = H / 2;        // 2-bit digits per half operand
  localparam int NL = $clog2(ND);   // combine levels above the 2x2 cells

  // 2x2 cell: vertical, crosswise, vertical.
  function automatic logic [3:0] cell2(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] r;
    r = {3'b000, x[0] & y[0]}
      + ({3'b000, x[1] & y[0]} << 1)
      + ({3'b000, x[0] & y[1]} << 1)
      + ({3'b000, x[1] & y[1]} << 2);
    return r;
  endfunction

  // Recursive Urdhva unrolled bottom-up: level lv merges 2x2 groups of blocks of 2<<lv bits.
  function automatic logic [HP-1:0] vedic_half(input logic [H-1:0] x, input logic [H-1:0] y);
    logic [HP-1:0] p [ND][ND];
    logic [HP-1:0] q [ND][ND];
    for (int i = 0; i < ND; i++) begin
      for (int j = 0; j < ND; j++) begin
        p[i][j] = HP'(cell2(x[2*i +: 2], y[2*j +: 2]));
      end
    end
    for (int lv = 0; lv < NL; lv++) begin
      q = p;
      for (int i = 0; i < (ND >> (lv + 1)); i++) begin
        for (int j = 0; j < (ND >> (lv + 1)); j++) begin
          q[i][j] = p[2*i][2*j]
                  + (p[2*i+1][2*j] << (2 << lv))
                  + (p[2*i][2*j+1] << (2 << lv))
                  + (p[2*i+1][2*j+1] << (4 << lv));
        end
      end
      p = q;
    end
    return p[0][0];
  endfunction

  logic             advance;
  logic             v1_q, v2_q, v3_q;
  logic [W-1:0]     ma_d, mb_d, ma_q, mb_q;
  logic             sign_d, s1_q, s2_q;
  logic [HP-1:0]    ll_d, hl_d, lh_d, hh_d;
  logic [HP-1:0]    ll_q, hl_q, lh_q, hh_q;
  logic [PW-1:0]    sum, prod_d, prod_q;

  assign advance   = ~(v3_q & ~out_ready);
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign product   = prod_q;

  // -2^(W-1) negates to itself, which read as unsigned is the correct magnitude.
  always_comb begin
    ma_d   = a;
    mb_d   = b;
    sign_d = 1'b0;
    if (is_signed) begin
      if (a[W-1]) ma_d = -a;
      if (b[W-1]) mb_d = -b;
      sign_d = a[W-1] ^ b[W-1];
    end
  end

  always_comb begin
    ll_d = vedic_half(ma_q[H-1:0], mb_q[H-1:0]);
    hl_d = vedic_half(ma_q[W-1:H], mb_q[H-1:0]);
    lh_d = vedic_half(ma_q[H-1:0], mb_q[W-1:H]);
    hh_d = vedic_half(ma_q[W-1:H], mb_q[W-1:H]);
  end

  always_comb begin
    sum    = PW'(ll_q) + (PW'(hl_q) << H) + (PW'(lh_q) << H) + (PW'(hh_q) << W);
    prod_d = s2_q ? -sum : sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (advance) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma_q   <= '0;
      mb_q   <= '0;
      s1_q   <= 1'b0;
      ll_q   <= '0;
      hl_q   <= '0;
      lh_q   <= '0;
      hh_q   <= '0;
      s2_q   <= 1'b0;
      prod_q <= '0;
    end else if (advance) begin
      ma_q   <= ma_d;
      mb_q   <= mb_d;
      s1_q   <= sign_d;
      ll_q   <= ll_d;
      hl_q   <= hl_d;
      lh_q   <= lh_d;
      hh_q   <= hh_d;
      s2_q   <= s1_q;
      prod_q <= prod_d;
    end
  end

endmodule

// File: doc/vedic_mul_pipe.md
VEDIC_MUL_PIPE -- requirements
Module: vedic_mul_pipe

Parameters
REQ-001 The module SHALL have parameter WIDTH, default 16, operand width; legal values 4, 8, 16, 32; other values SHALL fail elaboration.

Interface
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: the operand beat is valid.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-006 The module SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-007 The module SHALL have port is_signed, input, 1 bit: per-beat mode; 1 means two's-complement, 0 means unsigned.
REQ-008 The module SHALL have port out_valid, output, 1 bit: the product is valid.
REQ-009 The module SHALL have port out_ready, input, 1 bit: downstream accepts the product.
REQ-010 The module SHALL have port product, output, 2*WIDTH bits: the result.

Function
REQ-011 A beat SHALL be accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-012 A result SHALL be consumed when out_valid and out_ready are both 1 on a rising edge.
REQ-013 The datapath SHALL be a 3-stage pipeline: S1, S2 and S3.
- S1 registers the operand magnitudes and the result sign. In signed mode each magnitude is |x|, and the sign is a[MSB] XOR b[MSB]. In unsigned mode the operands pass unchanged and the sign is 0.
- S2 registers the four crosswise half-width Vedic partial products: lo*lo, hi*lo, lo*hi, hi*hi. Each is formed by recursive Urdhva-Tiryagbhyam down to 2x2 cells.
- S3 registers the shifted sum of the partial products, two's-complement negated when the sign is 1.
REQ-014 Latency SHALL be exactly 3 cycles from acceptance to out_valid when no stall occurs.
REQ-015 Throughput SHALL be one beat per cycle when out_ready is held at 1.
REQ-016 A stall condition SHALL exist when out_valid=1 and out_ready=0.
- While stalled, all stages SHALL hold.
- in_ready SHALL be 0 while stalled.
- No beat SHALL be lost or duplicated.
REQ-017 in_ready SHALL equal NOT (out_valid AND NOT out_ready).
REQ-018 Each stage SHALL carry its own valid bit. Bubbles SHALL propagate, and out_valid SHALL be the S3 valid bit.
REQ-019 product SHALL be bit-exact with a*b computed at 2*WIDTH bits, with operands interpreted per is_signed.
REQ-020 The magnitude of -2^(WIDTH-1) SHALL be carried as the unsigned value 2^(WIDTH-1), so that the extreme cases are exact.
- (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).
- (-2^(W-1))*(2^(W-1)-1) is exact.
REQ-021 is_signed SHALL be sampled per beat. Mixed-mode back-to-back beats SHALL each produce the result for their own mode.
REQ-022 product SHALL hold its value while out_valid=1 and out_ready=0.
REQ-023 product SHALL be don't-care when out_valid=0.

Reset
REQ-024 While rst=1, out_valid and all stage valid bits SHALL be 0, product SHALL be 0, and in_ready SHALL be 1.
REQ-025 Assertion of rst mid-operation SHALL discard all in-flight beats immediately and asynchronously. No stale result SHALL appear after release.
REQ-026 The first beat SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-027 Unsigned, WIDTH=16: a=0xFFFF, b=0xFFFF, out_ready=1 -> product=0xFFFE0001 with out_valid exactly 3 cycles after acceptance.
REQ-028 Signed, WIDTH=16: a=0x8000, b=0x8000 -> product=0x40000000. Also a=0x8000, b=0x7FFF -> product=0xC0008000. Also a=0xFFFF, b=0x0001 -> product=0xFFFFFFFF.
REQ-029 Stream test: 8 consecutive beats with alternating is_signed, out_ready=1 -> 8 correct products in order on 8 consecutive cycles.
REQ-030 Backpressure test: 5 beats offered with out_ready=0 for 6 cycles, then released.
- in_ready SHALL fall once out_valid=1.
- product SHALL stay stable during the stall.
- All 5 results SHALL appear in order with no loss or duplicates.
REQ-031 Reset test: rst pulsed while 2 beats are in flight -> out_valid=0 immediately, and no output appears afterwards until a new beat is accepted.
REQ-032 Parameter sweep: WIDTH = 4, 8 and 32, each with 1000 random beats in random mode under random out_ready -> every product SHALL match the reference model.
